collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
//  Parametrised multi-obstacle collision checker. Compares one player hitbox, sized by sprite pose,
//  against NUM_OBSTACLES obstacle slots, one slot per clock, under a start/busy/done handshake.
//  Reports a collision flag, per-slot hit mask, lowest hit index and hit count.
//  Sits between the sprite/obstacle position updaters and the game-state FSM; triggered once per frame.
// PARAMETERS
//  X_BITWIDTH       8   width of every x coordinate
//  Y_BITWIDTH       9   width of every y coordinate
//  NUM_OBSTACLES    4   obstacle slots scanned (>=1)
//  WIDTH_STAND      32  player box x-extent, standing
//  HEIGHT_STAND     64  player box y-extent, standing
//  WIDTH_CROUCH     36  player box x-extent, crouching
//  HEIGHT_CROUCH    42  player box y-extent, crouching
//  CROUCH_ID        4   sprite_id value selecting crouch dimensions
//  OBSTACLE_WIDTH   32  obstacle x-extent
//  OBSTACLE_HEIGHT  32  obstacle y-extent
//  MARGIN           0   player box shrunk by MARGIN on every side (forgiveness)
// PORTS
//  clock           in   1                  system clock, all logic on rising edge
//  reset           in   1                  synchronous, active-high
//  update          in   1                  start pulse; accepted only when busy==0
//  player_x        in   X_BITWIDTH         player box top-left x
//  player_y        in   Y_BITWIDTH         player box top-left y
//  sprite_id       in   4                  player pose; ==CROUCH_ID selects crouch box
//  obstacle_x      in   NUM_OBSTACLES*X_BITWIDTH  packed, slot i at [i*X_BITWIDTH +: X_BITWIDTH]
//  obstacle_y      in   NUM_OBSTACLES*Y_BITWIDTH  packed, same layout
//  obstacle_valid  in   NUM_OBSTACLES      slot i active; inactive slots never hit
//  busy            out  1                  high while scanning
//  done            out  1                  one-cycle pulse, results valid
//  collision       out  1                  |hit_mask
//  hit_mask        out  NUM_OBSTACLES      bit i = slot i overlapped player
//  first_hit       out  IDX_W              lowest hit slot index; 0 if none (IDX_W=max(1,clog2(N)))
//  hit_count       out  clog2(N+1)         number of hit slots
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, collision, hit_mask, first_hit, hit_count all 0. Overrides mid-scan:
//    scan aborted, no done pulse.
//  - States IDLE -> SCAN -> DONE. IDLE/DONE + update -> SCAN; DONE without update -> IDLE.
//    busy = (state==SCAN). update while busy is ignored, not queued.
//  - On accepting update (edge 0): snapshot player_x/y, sprite_id, all obstacle_x/y/valid;
//    clear scan index and scratch mask/count. Later input changes do not affect this scan.
//  - SCAN: cycle i+1 (i=0..N-1) evaluates slot i from the snapshot; index wraps to DONE after N-1.
//  - DONE (cycle N+1 after edge 0): done=1 for exactly one cycle; collision/hit_mask/first_hit/
//    hit_count load from scratch in the same edge and hold until the next DONE or reset.
//  - Latency update->done = N+1 cycles; back-to-back throughput one scan per N+1 cycles.
//  - Player box: w,h = crouch pair if sprite_id==CROUCH_ID else stand pair;
//    ax=player_x+MARGIN, ay=player_y+MARGIN, aw=w-2*MARGIN, ah=h-2*MARGIN.
//  - Hit(i) = valid[i] && ax<bx+OBSTACLE_WIDTH && ax+aw>bx && ay<by+OBSTACLE_HEIGHT && ay+ah>by.
//    Strict compares: edge-touching boxes do not collide.
//  - All sums computed at max(X_BITWIDTH,Y_BITWIDTH)+2 bits, zero-extended; no modular wrap
//    (box past screen edge never aliases to coordinate 0).
//  - first_hit = lowest i with hit; hit_count saturates never (width holds N).
// TESTING
//  1 reset held 3 cycles, then idle -> all outputs 0, busy 0, no done.
//  2 stand, player (100,200), slot0 (110,230) valid=0001 -> done exactly 5 cycles after update edge;
//    collision=1, hit_mask=0001, first_hit=0, hit_count=1.
//  3 slot0 at (132,200) edge-touch; then player x=250, slot0 x=5 -> collision=0 both (no wrap).
//  4 slot0 (134,210): sprite_id=0 -> no hit; sprite_id=4 (crouch) -> hit_mask=0001.
//  5 slots 1,2,3 overlapping, valid=1101 -> hit_mask=1100, first_hit=2, hit_count=2.
//  6 update again while busy -> ignored, single done; reset at scan cycle 2 -> no done, outputs 0.

Source files
------------

// File: rtl/collision_scanner.sv
// Sequential multi-obstacle collision checker: one snapshotted obstacle slot per clock,
// results published with a one-cycle done pulse after the last slot has been evaluated.
module collision_scanner #(
  parameter int unsigned X_BITWIDTH      = 8,
  parameter int unsigned Y_BITWIDTH      = 9,
  parameter int unsigned NUM_OBSTACLES   = 4,
  parameter int unsigned WIDTH_STAND     = 32,
  parameter int unsigned HEIGHT_STAND    = 64,
  parameter int unsigned WIDTH_CROUCH    = 36,
  parameter int unsigned HEIGHT_CROUCH   = 42,
  parameter int unsigned CROUCH_ID       = 4,
  parameter int unsigned OBSTACLE_WIDTH  = 32,
  parameter int unsigned OBSTACLE_HEIGHT = 32,
  parameter int unsigned MARGIN          = 0,
  localparam int unsigned IDX_W = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_OBSTACLES + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 update,
  input  logic [X_BITWIDTH-1:0]                player_x,
  input  logic [Y_BITWIDTH-1:0]                player_y,
  input  logic [3:0]                           sprite_id,
  input  logic [NUM_OBSTACLES*X_BITWIDTH-1:0]  obstacle_x,
  input  logic [NUM_OBSTACLES*Y_BITWIDTH-1:0]  obstacle_y,
  input  logic [NUM_OBSTACLES-1:0]             obstacle_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 collision,
  output logic [NUM_OBSTACLES-1:0]             hit_mask,
  output logic [IDX_W-1:0]                     first_hit,
  output logic [CNT_W-1:0]                     hit_count
);

  // Two guard bits so box extents past the screen edge never wrap back to 0.
  localparam int unsigned SW = ((X_BITWIDTH > Y_BITWIDTH) ? X_BITWIDTH : Y_BITWIDTH) + 2;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;
  logic   accept;
  logic   last;

  logic [X_BITWIDTH-1:0]               px_q;
  logic [Y_BITWIDTH-1:0]               py_q;
  logic [3:0]                          sprite_q;
  logic [NUM_OBSTACLES*X_BITWIDTH-1:0] ox_q;
  logic [NUM_OBSTACLES*Y_BITWIDTH-1:0] oy_q;
  logic [NUM_OBSTACLES-1:0]            valid_q;

  logic [IDX_W-1:0]         idx_q;
  logic [NUM_OBSTACLES-1:0] mask_q;
  logic [IDX_W-1:0]         first_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [SW-1:0] ax, ay, aw, ah, bx, by;
  logic          hit;
  int unsigned   slot;

  assign last = (idx_q == IDX_W'(NUM_OBSTACLES - 1));
  assign busy = (state_q == StScan);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (update) begin
          state_d = StScan;
          accept  = 1'b1;
        end
      end
      StScan: begin
        if (last) state_d = StDone;
      end
      StDone: begin
        if (update) begin
          state_d = StScan;
          accept  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    slot = 32'(idx_q);
    ax   = SW'(px_q) + SW'(MARGIN);
    ay   = SW'(py_q) + SW'(MARGIN);
    if (sprite_q == 4'(CROUCH_ID)) begin
      aw = SW'(WIDTH_CROUCH) - SW'(2 * MARGIN);
      ah = SW'(HEIGHT_CROUCH) - SW'(2 * MARGIN);
    end else begin
      aw = SW'(WIDTH_STAND) - SW'(2 * MARGIN);
      ah = SW'(HEIGHT_STAND) - SW'(2 * MARGIN);
    end
    bx  = SW'(ox_q[slot*X_BITWIDTH +: X_BITWIDTH]);
    by  = SW'(oy_q[slot*Y_BITWIDTH +: Y_BITWIDTH]);
    // Strict compares: boxes sharing only an edge do not collide.
    hit = valid_q[idx_q]
          && (ax < bx + SW'(OBSTACLE_WIDTH)) && (ax + aw > bx)
          && (ay < by + SW'(OBSTACLE_HEIGHT)) && (ay + ah > by);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      px_q      <= '0;
      py_q      <= '0;
      sprite_q  <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      valid_q   <= '0;
      idx_q     <= '0;
      mask_q    <= '0;
      first_q   <= '0;
      cnt_q     <= '0;
      done      <= 1'b0;
      collision <= 1'b0;
      hit_mask  <= '0;
      first_hit <= '0;
      hit_count <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == StDone);
      if (state_q == StDone) begin
        collision <= |mask_q;
        hit_mask  <= mask_q;
        first_hit <= first_q;
        hit_count <= cnt_q;
      end
      if (accept) begin
        px_q     <= player_x;
        py_q     <= player_y;
        sprite_q <= sprite_id;
        ox_q     <= obstacle_x;
        oy_q     <= obstacle_y;
        valid_q  <= obstacle_valid;
        idx_q    <= '0;
        mask_q   <= '0;
        first_q  <= '0;
        cnt_q    <= '0;
      end else if (state_q == StScan) begin
        idx_q <= last ? '0 : idx_q + IDX_W'(1);
        if (hit) begin
          mask_q[idx_q] <= 1'b1;
          cnt_q         <= cnt_q + CNT_W'(1);
          // Slots are scanned in ascending order, so the first hit seen is the lowest.
          if (cnt_q == '0) first_q <= idx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: directed vector table, handshake corner cases,
// and randomized scans against a box-overlap reference model.
module tb_collision_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic        update;
  logic [7:0]  player_x;
  logic [8:0]  player_y;
  logic [3:0]  sprite_id;
  logic [31:0] obstacle_x;
  logic [35:0] obstacle_y;
  logic [3:0]  obstacle_valid;
  logic        busy, done, collision;
  logic [3:0]  hit_mask;
  logic [1:0]  first_hit;
  logic [2:0]  hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  collision_scanner dut (
    .clock         (clock),
    .reset         (reset),
    .update        (update),
    .player_x      (player_x),
    .player_y      (player_y),
    .sprite_id     (sprite_id),
    .obstacle_x    (obstacle_x),
    .obstacle_y    (obstacle_y),
    .obstacle_valid(obstacle_valid),
    .busy          (busy),
    .done          (done),
    .collision     (collision),
    .hit_mask      (hit_mask),
    .first_hit     (first_hit),
    .hit_count     (hit_count)
  );

  typedef struct {
    logic [7:0]  px;
    logic [8:0]  py;
    logic [3:0]  sid;
    logic [31:0] ox;
    logic [35:0] oy;
    logic [3:0]  v;
    logic [3:0]  mask;
    logic [1:0]  first;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain integer geometry, no width limits, so nothing can wrap.
  function automatic bit model_hit(int px, int py, int sid, int ox, int oy, bit v);
    int w, h;
    w = (sid == 4) ? 36 : 32;
    h = (sid == 4) ? 42 : 64;
    return v && (px < ox + 32) && (px + w > ox) && (py < oy + 32) && (py + h > oy);
  endfunction

  // Starts a scan, scrambles inputs after the accept edge, waits for done; returns latency.
  task automatic run_scan(input vec_t t, output int lat);
    @(negedge clock);
    player_x = t.px; player_y = t.py; sprite_id = t.sid;
    obstacle_x = t.ox; obstacle_y = t.oy; obstacle_valid = t.v;
    update = 1'b1;
    @(posedge clock);
    #1;
    update = 1'b0;
    player_x = 8'($urandom); player_y = 9'($urandom); sprite_id = 4'($urandom);
    obstacle_x = $urandom; obstacle_y = {4'($urandom), $urandom}; obstacle_valid = 4'hf;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_results(input string name, input vec_t t, input int lat);
    check({name, " latency"}, lat, 5);
    check({name, " collision"}, int'(collision), int'(t.mask != 0));
    check({name, " hit_mask"}, int'(hit_mask), int'(t.mask));
    check({name, " first_hit"}, int'(first_hit), int'(t.first));
    check({name, " hit_count"}, int'(hit_count), int'(t.cnt));
    @(posedge clock);
    #1;
    check({name, " done one cycle"}, int'(done), 0);
  endtask

  initial begin
    int   lat, ndone;
    vec_t r;

    tbl[0] = '{8'd100, 9'd200, 4'd0, {24'd0, 8'd110}, {27'd0, 9'd230}, 4'b0001, 4'b0001, 2'd0, 3'd1};
    tbl[1] = '{8'd100, 9'd200, 4'd0, {24'd0, 8'd132}, {27'd0, 9'd200}, 4'b0001, 4'b0000, 2'd0, 3'd0};
    tbl[2] = '{8'd250, 9'd200, 4'd0, {24'd0, 8'd5},   {27'd0, 9'd200}, 4'b0001, 4'b0000, 2'd0, 3'd0};
    tbl[3] = '{8'd100, 9'd200, 4'd0, {24'd0, 8'd134}, {27'd0, 9'd210}, 4'b0001, 4'b0000, 2'd0, 3'd0};
    tbl[4] = '{8'd100, 9'd200, 4'd4, {24'd0, 8'd134}, {27'd0, 9'd210}, 4'b0001, 4'b0001, 2'd0, 3'd1};
    tbl[5] = '{8'd100, 9'd200, 4'd0, {8'd110, 8'd110, 8'd110, 8'd0},
               {9'd230, 9'd230, 9'd230, 9'd0}, 4'b1101, 4'b1100, 2'd2, 3'd2};
    tbl[6] = '{8'd100, 9'd200, 4'd0, {8'd90, 8'd120, 8'd100, 8'd80},
               {9'd180, 9'd250, 9'd200, 9'd230}, 4'b1111, 4'b1111, 2'd0, 3'd4};
    tbl[7] = '{8'd100, 9'd200, 4'd0, {24'd0, 8'd110}, {27'd0, 9'd264}, 4'b0001, 4'b0000, 2'd0, 3'd0};
    tbl[8] = '{8'd100, 9'd200, 4'd0, {8'd110, 16'd0, 8'd110}, {9'd263, 18'd0, 9'd168},
               4'b1001, 4'b1000, 2'd3, 3'd1};
    tbl[9] = '{8'd100, 9'd200, 4'd4, {8'd110, 8'd110, 16'd0}, {9'd241, 9'd242, 18'd0},
               4'b1111, 4'b1000, 2'd3, 3'd1};

    reset = 1'b1; update = 1'b0;
    player_x = '0; player_y = '0; sprite_id = '0;
    obstacle_x = '0; obstacle_y = '0; obstacle_valid = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clock);
      #1;
      if (done || busy) ndone++;
    end
    check("reset busy/done activity", ndone, 0);
    check("reset collision", int'(collision), 0);
    check("reset hit_mask", int'(hit_mask), 0);
    check("reset first_hit", int'(first_hit), 0);
    check("reset hit_count", int'(hit_count), 0);

    for (int i = 0; i < 10; i++) begin
      run_scan(tbl[i], lat);
      check_results($sformatf("vec%0d", i), tbl[i], lat);
    end

    // Update while busy is ignored: exactly one done, at the normal latency.
    @(negedge clock);
    player_x = 8'd100; player_y = 9'd200; sprite_id = 4'd0;
    obstacle_x = {24'd0, 8'd110}; obstacle_y = {27'd0, 9'd230}; obstacle_valid = 4'b0001;
    update = 1'b1;
    @(posedge clock);
    #1;
    update = 1'b0;
    check("busy after accept", int'(busy), 1);
    ndone = 0; lat = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 2) update = 1'b1;
      if (n == 3) update = 1'b0;
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
    end
    check("busy update done count", ndone, 1);
    check("busy update latency", lat, 5);
    check("busy update hit_mask", int'(hit_mask), 1);

    // Reset in scan cycle 2 aborts the scan: no done, outputs cleared.
    @(negedge clock);
    obstacle_valid = 4'b0001;
    update = 1'b1;
    @(posedge clock);
    #1;
    update = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      if (done || busy) ndone++;
      @(posedge clock);
      #1;
    end
    check("abort activity", ndone, 0);
    check("abort collision", int'(collision), 0);
    check("abort hit_mask", int'(hit_mask), 0);

    for (int k = 0; k < 40; k++) begin
      r.px  = 8'($urandom);
      r.py  = 9'($urandom);
      r.sid = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'($urandom);
      r.v   = 4'($urandom);
      r.ox  = '0;
      r.oy  = '0;
      r.mask = '0; r.first = '0; r.cnt = '0;
      for (int s = 0; s < 4; s++) begin
        r.ox[s*8 +: 8] = 8'(int'(r.px) + $urandom_range(0, 90) - 45);
        r.oy[s*9 +: 9] = 9'(int'(r.py) + $urandom_range(0, 120) - 50);
      end
      for (int s = 3; s >= 0; s--) begin
        if (model_hit(int'(r.px), int'(r.py), int'(r.sid), int'(r.ox[s*8 +: 8]),
                      int'(r.oy[s*9 +: 9]), r.v[s])) begin
          r.mask[s] = 1'b1;
          r.first   = 2'(s);
          r.cnt     = r.cnt + 3'd1;
        end
      end
      run_scan(r, lat);
      check_results($sformatf("rand%0d", k), r, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
